fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction prefetch buffer between the fetch-side memory read port (port A of `memcontrol`) and `stage_decode`. It generates sequential fetch addresses and tracks the single in-flight synchronous read. Returned words are queued with their PCs and presented to decode over a valid/ready handshake. A jump from execute flushes the queue and squashes the stale in-flight read, so decode never sees wrong-path instructions.

## Interface
Parameters:
- `DEPTH`, 4: queue entries; power of two, ≥ 2.
- `RESET_PC`, 32'h00000000: first fetch address after reset; bits [1:0] must be 0.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `jump`  in  1  redirect request from execute.
- `jump_addr`  in  32  redirect target; bits [1:0] ignored.
- `mem_req`  out  1  a fetch is issued this cycle.
- `mem_addr`  out  30  word address to memory port A (byte PC [31:2]).
- `mem_data`  in  32  read data; valid the cycle after the matching `mem_req`.
- `out_valid`  out  1  `out_instr`/`out_pc` hold a valid instruction.
- `out_instr`  out  32  instruction word.
- `out_pc`  out  32  byte PC of `out_instr`; bits [1:0] = 0.
- `out_ready`  in  1  decode accepts; a transfer occurs when `out_valid && out_ready`.

## Operation
- State:
  - `fetch_pc` (32b): next address to issue.
  - Queue of `{pc, instr}`: `DEPTH` entries, occupancy `count` (0..DEPTH).
  - `inflight` flag and `inflight_pc`: describe the outstanding read.
- Issue rule, non-jump cycle:
  - `mem_req = (count + inflight < DEPTH)`, using registered `count` only. A pop in the same cycle gives no credit.
  - On issue: `mem_addr = fetch_pc[31:2]`; `fetch_pc <= fetch_pc + 4` (wraps mod 2^32); `inflight <= 1`; `inflight_pc <= fetch_pc`.
  - No issue: `inflight <= 0`.
  - `mem_addr` equals `fetch_pc[31:2]` whenever `mem_req = 0`.
- Return: when `inflight = 1` and `jump = 0`, `{inflight_pc, mem_data}` is pushed in the same cycle. The issue rule guarantees space, so there is no overflow.
- Pop: on a transfer, the head entry is removed. Push and pop in the same cycle leave `count` unchanged.
- Jump cycle (`jump = 1`), which overrides everything else:
  - `out_valid` is forced to 0 combinationally; no pop occurs.
  - `mem_data` from any in-flight read is discarded.
  - The queue is cleared (`count <= 0`).
  - `mem_req = 1` with `mem_addr = jump_addr[31:2]`.
  - `inflight <= 1`; `inflight_pc <= {jump_addr[31:2], 2'b00}`; `fetch_pc <= {jump_addr[31:2], 2'b00} + 4`.
- Back-to-back jumps: each one restarts fetch at its own target. Only the last target's stream survives.

## Timing
- Reset (asynchronous assert, synchronous-safe release): `count = 0`, `inflight = 0`, `fetch_pc = RESET_PC`.
  - While reset is asserted: `mem_req = 0`, `out_valid = 0`, `out_instr = 0`, `out_pc = 0`.
  - `out_instr`/`out_pc` read 0 whenever the queue is empty.
- First cycle after release: `mem_req = 1`, `mem_addr = RESET_PC[31:2]`.
- Reset asserted mid-operation drops the queue and any in-flight read immediately.
- Fetch-to-decode latency, without bypass: issue in cycle t, push at end of t+1, `out_valid` in t+2.
- Jump in cycle t: target instruction visible in t+2, or t+1 with bypass.
- Steady state with `out_ready = 1`: one instruction per cycle after the pipeline fills.
- `out_valid` with `out_ready = 0`: `out_instr`/`out_pc` held stable until the transfer or a jump.

## Configuration
- `FETCH_BUFFER_BYPASS_EN` defined:
  - When `count = 0`, `inflight = 1` and `jump = 0`, the returning word drives `out_valid`/`out_instr`/`out_pc` combinationally.
  - If `out_ready = 1` it is consumed and not pushed; otherwise it is pushed as usual.
  - Latency drops by one cycle.
- Undefined: every returned word passes through the queue; the outputs are purely registered state, so there is no `mem_data`-to-`out_*` combinational path.

## Structure
- Shared package `mollusc_pkg`: `XLEN = 32`, `word_t`, `fetch_entry_t` (`{pc, instr}`), and `RESET_PC_DEFAULT`.
- Sub-module `fetch_fifo`: a generic synchronous FIFO of `fetch_entry_t` with `DEPTH`, push, pop, synchronous `flush` (priority over push), and a `count` output.
  - `fetch_buffer` holds the issue/in-flight/jump control and the bypass mux.

## Test plan
- Reset release with `out_ready = 1`, memory returning `mem[a] = a`, `RESET_PC = 0`: PCs 0, 4, 8, … appear one per cycle starting at cycle 2 (cycle 1 with bypass); the first `out_instr` is 0.
- `out_ready = 0` for 10 cycles: `mem_req` stops after exactly `DEPTH` issues and `count = DEPTH`. Raising `out_ready` drains 0, 4, 8, 12 in order with no loss or duplicate.
- Jump to 0x100 while the queue holds 3 entries and a read is in flight: the next `out_pc` is 0x100, and no PC in the range 0x0–0xC is delivered after the jump cycle.
- Jumps to 0x200 and then 0x300 on consecutive cycles: the first delivered PC is 0x300, followed by 0x304.
- `jump_addr = 0x103`: `mem_addr = 0x40`, `out_pc = 0x100`, next fetch 0x104. `fetch_pc = 0xFFFFFFFC` wraps to 0.
- Assert `rst_n = 0` mid-stream with a full queue: outputs are 0 asynchronously, and after release fetching restarts at `RESET_PC`.

Source files
------------

// File: rtl/mollusc_pkg.sv
// Shared types for the mollusc core: machine word, fetch queue entry, reset PC.
package mollusc_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

  localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush (priority over push) and occupancy count.
module fetch_fifo
  import mollusc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  fetch_entry_t               push_data,
  input  logic                       pop,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  fetch_entry_t   store [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;

  assign head = store[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage carries data only, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (push && !flush) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_buffer.sv
// Instruction prefetch buffer: sequential fetch issue, single in-flight read, jump flush.
// Optional FETCH_BUFFER_BYPASS_EN forwards a returning word straight to decode when the queue is empty.
module fetch_buffer
  import mollusc_pkg::*;
#(
  parameter int    DEPTH    = 4,
  parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        jump,
  input  logic [31:0] jump_addr,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  input  logic [31:0] mem_data,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] count;
  fetch_entry_t  head;
  fetch_entry_t  push_entry;
  logic          push;
  logic          pop;
  logic          empty;
  logic          issue;
  logic          inflight;
  word_t         fetch_pc;
  word_t         inflight_pc;
  word_t         jump_pc;
  logic          unused_jump_lsbs;

  assign unused_jump_lsbs = ^jump_addr[1:0];
  assign jump_pc          = {jump_addr[31:2], 2'b00};
  assign empty            = (count == '0);

  // Credit uses registered occupancy only; a pop this cycle frees nothing until next cycle.
  assign issue    = rst_n && (jump || ((count + CW'(inflight)) < CW'(DEPTH)));
  assign mem_req  = issue;
  assign mem_addr = jump ? jump_addr[31:2] : fetch_pc[31:2];

  assign push_entry = '{pc: inflight_pc, instr: mem_data};

`ifdef FETCH_BUFFER_BYPASS_EN
  logic byp;
  assign byp       = empty && inflight && !jump;
  assign out_valid = !jump && (!empty || byp);
  assign out_instr = !empty ? head.instr : (byp ? mem_data    : '0);
  assign out_pc    = !empty ? head.pc    : (byp ? inflight_pc : '0);
  assign push      = inflight && !jump && !(byp && out_ready);
`else
  assign out_valid = !jump && !empty;
  assign out_instr = empty ? '0 : head.instr;
  assign out_pc    = empty ? '0 : head.pc;
  assign push      = inflight && !jump;
`endif

  assign pop = out_valid && out_ready && !empty;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (jump),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (jump)       fetch_pc <= jump_pc + 32'd4;
      else if (issue) fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // PC tag of the outstanding read; only meaningful while inflight is set.
  always_ff @(posedge clk) begin
    if (jump)       inflight_pc <= jump_pc;
    else if (issue) inflight_pc <= fetch_pc;
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed table-driven bench for fetch_buffer (default build, DEPTH=4, RESET_PC=0).
module tb_fetch_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_addr = 32'd0;
  logic        mem_req;
  logic [29:0] mem_addr;
  logic [31:0] mem_data = 32'd0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_ready = 1'b1;

  int errors = 0;
  int checks = 0;

  fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .jump      (jump),
    .jump_addr (jump_addr),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_valid (out_valid),
    .out_instr (out_instr),
    .out_pc    (out_pc),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Synchronous memory: word at byte address a holds a.
  always @(posedge clk) begin
    if (mem_req) mem_data <= {mem_addr, 2'b00};
  end

  typedef struct {
    logic        jmp;
    logic [31:0] jaddr;
    logic        rdy;
    logic        req;
    logic [29:0] addr;
    logic        vld;
    logic        emp;
    logic [31:0] pc;
  } vec_t;

  vec_t tbl[26];

  task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  initial begin
    tbl[0]  = '{1'b0, 32'h0,        1'b1, 1'b1, 30'h0,        1'b0, 1'b1, 32'h0};
    tbl[1]  = '{1'b0, 32'h0,        1'b1, 1'b1, 30'h1,        1'b0, 1'b1, 32'h0};
    tbl[2]  = '{1'b0, 32'h0,        1'b1, 1'b1, 30'h2,        1'b1, 1'b0, 32'h0};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b1, 30'h3,        1'b1, 1'b0, 32'h4};
    tbl[4]  = '{1'b1, 32'h103,      1'b1, 1'b1, 30'h40,       1'b0, 1'b0, 32'h0};
    tbl[5]  = '{1'b0, 32'h0,        1'b1, 1'b1, 30'h41,       1'b0, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 32'h0,        1'b1, 1'b1, 30'h42,       1'b1, 1'b0, 32'h100};
    tbl[7]  = '{1'b0, 32'h0,        1'b0, 1'b1, 30'h43,       1'b1, 1'b0, 32'h104};
    tbl[8]  = '{1'b0, 32'h0,        1'b0, 1'b1, 30'h44,       1'b1, 1'b0, 32'h104};
    tbl[9]  = '{1'b0, 32'h0,        1'b0, 1'b0, 30'h45,       1'b1, 1'b0, 32'h104};
    tbl[10] = '{1'b0, 32'h0,        1'b0, 1'b0, 30'h45,       1'b1, 1'b0, 32'h104};
    tbl[11] = '{1'b0, 32'h0,        1'b1, 1'b0, 30'h45,       1'b1, 1'b0, 32'h104};
    tbl[12] = '{1'b0, 32'h0,        1'b1, 1'b1, 30'h45,       1'b1, 1'b0, 32'h108};
    tbl[13] = '{1'b0, 32'h0,        1'b1, 1'b1, 30'h46,       1'b1, 1'b0, 32'h10C};
    tbl[14] = '{1'b0, 32'h0,        1'b1, 1'b1, 30'h47,       1'b1, 1'b0, 32'h110};
    tbl[15] = '{1'b0, 32'h0,        1'b1, 1'b1, 30'h48,       1'b1, 1'b0, 32'h114};
    tbl[16] = '{1'b1, 32'h200,      1'b1, 1'b1, 30'h80,       1'b0, 1'b0, 32'h0};
    tbl[17] = '{1'b1, 32'h300,      1'b1, 1'b1, 30'hC0,       1'b0, 1'b1, 32'h0};
    tbl[18] = '{1'b0, 32'h0,        1'b1, 1'b1, 30'hC1,       1'b0, 1'b1, 32'h0};
    tbl[19] = '{1'b0, 32'h0,        1'b1, 1'b1, 30'hC2,       1'b1, 1'b0, 32'h300};
    tbl[20] = '{1'b0, 32'h0,        1'b1, 1'b1, 30'hC3,       1'b1, 1'b0, 32'h304};
    tbl[21] = '{1'b1, 32'hFFFFFFF8, 1'b1, 1'b1, 30'h3FFFFFFE, 1'b0, 1'b0, 32'h0};
    tbl[22] = '{1'b0, 32'h0,        1'b1, 1'b1, 30'h3FFFFFFF, 1'b0, 1'b1, 32'h0};
    tbl[23] = '{1'b0, 32'h0,        1'b1, 1'b1, 30'h0,        1'b1, 1'b0, 32'hFFFFFFF8};
    tbl[24] = '{1'b0, 32'h0,        1'b1, 1'b1, 30'h1,        1'b1, 1'b0, 32'hFFFFFFFC};
    tbl[25] = '{1'b0, 32'h0,        1'b1, 1'b1, 30'h2,        1'b1, 1'b0, 32'h0};

    // Reset held: outputs quiet.
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req",   -1, 32'(mem_req),   32'h0);
    chk("rst_out_valid", -1, 32'(out_valid), 32'h0);
    chk("rst_out_pc",    -1, out_pc,         32'h0);
    chk("rst_out_instr", -1, out_instr,      32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 26; i++) begin
      if (i > 0) @(negedge clk);
      jump      = tbl[i].jmp;
      jump_addr = tbl[i].jaddr;
      out_ready = tbl[i].rdy;
      #1;
      chk("mem_req",   i, 32'(mem_req),   32'(tbl[i].req));
      chk("mem_addr",  i, 32'(mem_addr),  32'(tbl[i].addr));
      chk("out_valid", i, 32'(out_valid), 32'(tbl[i].vld));
      if (tbl[i].vld) begin
        chk("out_pc",    i, out_pc,    tbl[i].pc);
        chk("out_instr", i, out_instr, tbl[i].pc);
      end
      if (tbl[i].emp) begin
        chk("empty_pc",    i, out_pc,    32'h0);
        chk("empty_instr", i, out_instr, 32'h0);
      end
    end

    // Fill the queue with decode stalled, then reset mid-stream.
    jump = 1'b0;
    jump_addr = 32'h0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      out_ready = 1'b0;
    end
    @(negedge clk);
    #1;
    chk("full_mem_req",   100, 32'(mem_req),   32'h0);
    chk("full_out_valid", 100, 32'(out_valid), 32'h1);
    chk("full_out_pc",    100, out_pc,         32'h4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mem_req",   101, 32'(mem_req),   32'h0);
    chk("async_out_valid", 101, 32'(out_valid), 32'h0);
    chk("async_out_pc",    101, out_pc,         32'h0);
    chk("async_out_instr", 101, out_instr,      32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("restart_mem_req",  102, 32'(mem_req),  32'h1);
    chk("restart_mem_addr", 102, 32'(mem_addr), 32'h0);
    chk("restart_valid0",   102, 32'(out_valid), 32'h0);
    repeat (2) @(negedge clk);
    #1;
    chk("restart_out_valid", 104, 32'(out_valid), 32'h1);
    chk("restart_out_pc",    104, out_pc,         32'h0);
    @(negedge clk);
    #1;
    chk("restart_next_pc",    105, out_pc,    32'h4);
    chk("restart_next_instr", 105, out_instr, 32'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
